qdec_ctx_arbiter: RTL and testbench
===================================

# qdec_ctx_arbiter

Arbiter and sequencer for the CABAC context-state memory (`qdec_ctx_mem`, single-port, 1024 × 8, 1-cycle read latency). It shares the memory port between three agents:
- slice-init writes from the context FSM;
- context reads requested by the FSM on behalf of the arithmetic decoder;
- state write-backs from the arithmetic decoder.

It also performs read-after-write forwarding, so the decoder never sees a stale probability state.

## Interface
Parameters:
- `ADDR_W`, 10: context memory address width.
- `STATE_W`, 7: context state width. Bit map is `{pStateIdx[5:0], valMps}`; memory word is `{1'b0, state}`.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `init_vld` in 1, `init_addr` in ADDR_W, `init_data` in STATE_W, `init_rdy` out 1: FSM init-write channel.
- `rd_req` in 1, `rd_addr` in ADDR_W, `rd_gnt` out 1: FSM context-read request. The request is accepted when `rd_req & rd_gnt`.
- `ctxState` out STATE_W, `ctxState_vld` out 1, `ctxState_rdy` in 1: state delivered to the arithmetic decoder.
- `ctxStateUpdate` in STATE_W, `ctxStateUpdate_vld` in 1, `ctxStateUpdate_rdy` out 1: updated state from the arithmetic decoder. The target address is implicit: the last delivered address.
- `ctx_addr` out ADDR_W, `ctx_wdata` out 8, `ctx_rdata` in 8, `ctx_we` out 1, `ctx_re` out 1: memory port. `ctx_we` and `ctx_re` are never both high.
- `busy` out 1: high when the read FSM is not in IDLE or a write-back is owed.

## Operation
- Port priority per cycle, fixed: write-back > init write > read. At most one memory access per cycle.
- Write-back:
  - `ctxStateUpdate_rdy` = 1 at all times.
  - On `ctxStateUpdate_vld`: `ctx_we`=1, `ctx_addr`=`upd_addr`, `ctx_wdata`={0,`ctxStateUpdate`}, same cycle (combinational path).
- Init:
  - `init_rdy` = !`ctxStateUpdate_vld`.
  - On handshake: `ctx_we`=1, `ctx_addr`=`init_addr`.
- Read FSM states: IDLE, RD, HOLD.
  - IDLE: `rd_gnt` = !`ctxStateUpdate_vld` & !`init_vld`. On an accepted read: `ctx_re`=1, `ctx_addr`=`rd_addr`, latch `rd_addr` into `pend_addr`, go to RD.
  - RD: capture `ctx_rdata[6:0]` into the output register, then go to HOLD.
    - Forwarding: if a write (either source) targets `pend_addr` in this cycle, capture that write's data instead.
  - HOLD: `ctxState_vld`=1.
    - Any write to `pend_addr` while in HOLD overwrites the output register. `ctxState_vld` stays high; new data is visible the next cycle.
    - On `ctxState_rdy`: `upd_addr` <= `pend_addr`, go to IDLE.
- Write-back uses `upd_addr`. A write-back that arrives with no preceding delivery since reset is still written, to `upd_addr` (reset value 0). The decoder must not do this; the bench flags it as an assertion.
- Only one read is outstanding. `rd_gnt`=0 outside IDLE.

## Timing
- Read latency: accepted at cycle t (`ctx_re` at t), data in RD at t+1, `ctxState_vld` from t+2. Back-to-back reads: the next grant comes no earlier than the cycle after the `ctxState` handshake.
- Write latency: 0 cycles to the memory port. The write is visible to the next memory read one cycle later.
- Simultaneous `ctxStateUpdate_vld` and `init_vld`: the update is written. `init_rdy`=0, and the init must be held by the FSM.
- Read request while `init_vld` is high: the read is stalled. This cannot starve the read, because the FSM stops init before decoding.
- Reset values:
  - outputs: `ctxState`=0, `ctxState_vld`=0, `rd_gnt`=0 during reset, `init_rdy`=1, `ctx_we`=0, `ctx_re`=0, `busy`=0;
  - internal: FSM=IDLE, `upd_addr`=0, `pend_addr`=0.
- Reset mid-operation, any state: return to IDLE next cycle. An in-flight read is discarded and no write is issued.

## Test plan
- **Init sweep:** write addresses 0..1023 with data `addr[6:0]`, then read back 5, 700 and 1023. Expect `ctxState` = 0x05, 0x3C, 0x7F, each with `ctxState_vld` rising exactly 2 cycles after the grant.
- **RAW forwarding in RD:** read addr 12 (mem 0x20) at t, deliver, then at t+1 a write-back to 12 with 0x21. Expect the delivered value 0x21, not 0x20.
- **HOLD overwrite:** read addr 40 (0x10) and hold `ctxState_rdy`=0. An init write to 40 with 0x55 must change `ctxState` to 0x55 next cycle, with `ctxState_vld` continuous. An init write to 41 must leave it unchanged.
- **Priority collision:** in the same cycle, `ctxStateUpdate_vld`, `init_vld` and `rd_req`. Expect: update written first, `init_rdy`=0, `rd_gnt`=0; next cycle init written; cycle after that the read is granted. Never `ctx_we` & `ctx_re`.
- **Decode loop:** 200 random read/update pairs over 8 addresses against a reference model. Every delivered state must equal the model.
- **Reset in HOLD:** apply `rst` for 1 cycle. Next cycle `ctxState_vld`=0, `busy`=0, no memory access, and a new read is granted normally.

Source files
------------

// File: rtl/qdec_ctx_arbiter.sv
// Arbiter/sequencer for the CABAC context-state memory: shares one port between
// decoder write-backs, slice-init writes and context reads, with RAW forwarding.
module qdec_ctx_arbiter #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned STATE_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_vld,
  input  logic [ADDR_W-1:0]  init_addr,
  input  logic [STATE_W-1:0] init_data,
  output logic               init_rdy,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_gnt,
  output logic [STATE_W-1:0] ctxState,
  output logic               ctxState_vld,
  input  logic               ctxState_rdy,
  input  logic [STATE_W-1:0] ctxStateUpdate,
  input  logic               ctxStateUpdate_vld,
  output logic               ctxStateUpdate_rdy,
  output logic [ADDR_W-1:0]  ctx_addr,
  output logic [7:0]         ctx_wdata,
  input  logic [7:0]         ctx_rdata,
  output logic               ctx_we,
  output logic               ctx_re,
  output logic               busy
);

  localparam int unsigned MemW = 8;

  typedef enum logic [1:0] {IDLE, RD, HOLD} rdState_t;

  rdState_t           state;
  rdState_t           stateNext;
  logic [ADDR_W-1:0]  pendAddr;
  logic [ADDR_W-1:0]  updAddr;
  logic [STATE_W-1:0] stateQ;
  logic               owed;
  logic [STATE_W-1:0] wrData;
  logic               wbWe;
  logic               initWe;
  logic               rdAccept;
  logic               wrHit;
  logic               unusedRdata;

  assign unusedRdata = ctx_rdata[MemW-1];

  // Port arbitration (write-back > init > read) and read FSM next state
  always_comb begin
    stateNext = state;
    wbWe      = ctxStateUpdate_vld;
    initWe    = init_vld & ~ctxStateUpdate_vld;
    rd_gnt    = (state == IDLE) & ~ctxStateUpdate_vld & ~init_vld & ~rst;
    rdAccept  = rd_req & rd_gnt;
    ctx_we    = wbWe | initWe;
    ctx_re    = rdAccept;
    wrData    = wbWe ? ctxStateUpdate : init_data;
    ctx_addr  = wbWe ? updAddr : (initWe ? init_addr : rd_addr);
    ctx_wdata = MemW'({1'b0, wrData});
    wrHit     = ctx_we & (ctx_addr == pendAddr);
    case (state)
      IDLE:    if (rdAccept) stateNext = RD;
      RD:      stateNext = HOLD;
      HOLD:    if (ctxState_rdy) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // A write landing on the pending address wins over the stale memory data
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pendAddr <= '0;
      updAddr  <= '0;
      stateQ   <= '0;
      owed     <= 1'b0;
    end else begin
      state <= stateNext;
      if (rdAccept) pendAddr <= rd_addr;
      if (state == RD) begin
        stateQ <= wrHit ? wrData : ctx_rdata[STATE_W-1:0];
      end else if ((state == HOLD) && wrHit) begin
        stateQ <= wrData;
      end
      if ((state == HOLD) && ctxState_rdy) begin
        updAddr <= pendAddr;
        owed    <= 1'b1;
      end else if (wbWe) begin
        owed <= 1'b0;
      end
    end
  end

  assign ctxState           = stateQ;
  assign ctxState_vld       = (state == HOLD);
  assign busy               = (state != IDLE) | owed;
  assign ctxStateUpdate_rdy = 1'b1;
  assign init_rdy           = ~ctxStateUpdate_vld;

endmodule

// File: tb/tb_qdec_ctx_arbiter.sv
// Directed self-checking bench for qdec_ctx_arbiter with a behavioural 1024x8
// single-port memory (1-cycle read latency).
module tb_qdec_ctx_arbiter;

  logic       clk;
  logic       rst;
  logic       init_vld;
  logic [9:0] init_addr;
  logic [6:0] init_data;
  logic       init_rdy;
  logic       rd_req;
  logic [9:0] rd_addr;
  logic       rd_gnt;
  logic [6:0] ctxState;
  logic       ctxState_vld;
  logic       ctxState_rdy;
  logic [6:0] ctxStateUpdate;
  logic       ctxStateUpdate_vld;
  logic       ctxStateUpdate_rdy;
  logic [9:0] ctx_addr;
  logic [7:0] ctx_wdata;
  logic [7:0] ctx_rdata;
  logic       ctx_we;
  logic       ctx_re;
  logic       busy;

  int nAssert = 0;
  int nFail   = 0;
  int weReBoth = 0;
  int badWb    = 0;
  logic anyDelivered = 1'b0;

  logic [7:0] mem [0:1023];
  logic [6:0] model [0:7];

  qdec_ctx_arbiter #(.ADDR_W(10), .STATE_W(7)) dut (
    .clk(clk), .rst(rst),
    .init_vld(init_vld), .init_addr(init_addr), .init_data(init_data), .init_rdy(init_rdy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .ctxState(ctxState), .ctxState_vld(ctxState_vld), .ctxState_rdy(ctxState_rdy),
    .ctxStateUpdate(ctxStateUpdate), .ctxStateUpdate_vld(ctxStateUpdate_vld),
    .ctxStateUpdate_rdy(ctxStateUpdate_rdy),
    .ctx_addr(ctx_addr), .ctx_wdata(ctx_wdata), .ctx_rdata(ctx_rdata),
    .ctx_we(ctx_we), .ctx_re(ctx_re), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ctx_we) mem[ctx_addr] <= ctx_wdata;
    if (ctx_re) ctx_rdata <= mem[ctx_addr];
  end

  // Protocol monitors: port exclusivity and write-back ordering
  always @(negedge clk) begin
    if (ctx_we && ctx_re) weReBoth++;
    if (rst) anyDelivered = 1'b0;
    else begin
      if (ctxStateUpdate_vld && !anyDelivered) badWb++;
      if (ctxState_vld && ctxState_rdy) anyDelivered = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic initWrite(input logic [9:0] a, input logic [6:0] d);
    init_vld = 1'b1; init_addr = a; init_data = d;
    step();
    init_vld = 1'b0;
  endtask

  // Issues a read in IDLE; returns positioned in the RD cycle
  task automatic readStart(input string tag, input logic [9:0] a);
    rd_req = 1'b1; rd_addr = a;
    #1;
    chk({tag, "_gnt"}, 32'(rd_gnt), 32'd1);
    chk({tag, "_re"}, 32'(ctx_re), 32'd1);
    step();
    rd_req = 1'b0;
  endtask

  task automatic deliver();
    ctxState_rdy = 1'b1;
    step();
    ctxState_rdy = 1'b0;
  endtask

  task automatic readExpect(input string tag, input logic [9:0] a, input logic [6:0] exp);
    readStart(tag, a);
    #1;
    chk({tag, "_vld_t1"}, 32'(ctxState_vld), 32'd0);
    step();
    #1;
    chk({tag, "_vld_t2"}, 32'(ctxState_vld), 32'd1);
    chk({tag, "_data"}, 32'(ctxState), 32'(exp));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    deliver();
  endtask

  initial begin
    logic [2:0] a;
    logic [6:0] nv;
    rst = 1'b1; init_vld = 1'b0; init_addr = '0; init_data = '0;
    rd_req = 1'b0; rd_addr = '0; ctxState_rdy = 1'b0;
    ctxStateUpdate = '0; ctxStateUpdate_vld = 1'b0;
    step();
    step();
    #1;
    chk("rst_gnt", 32'(rd_gnt), 32'd0);
    chk("rst_init_rdy", 32'(init_rdy), 32'd1);
    chk("rst_we", 32'(ctx_we), 32'd0);
    chk("rst_re", 32'(ctx_re), 32'd0);
    chk("rst_state", 32'(ctxState), 32'd0);
    chk("rst_vld", 32'(ctxState_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("upd_rdy", 32'(ctxStateUpdate_rdy), 32'd1);
    rst = 1'b0;
    #1;
    chk("post_rst_gnt", 32'(rd_gnt), 32'd1);
    step();

    // Init sweep, then spot reads
    for (int i = 0; i < 1024; i++) begin
      init_vld = 1'b1; init_addr = 10'(i); init_data = 7'(i);
      #1;
      if (i == 0) begin
        chk("init_we", 32'(ctx_we), 32'd1);
        chk("init_gnt_blocked", 32'(rd_gnt), 32'd0);
      end
      step();
    end
    init_vld = 1'b0;
    readExpect("sweep5", 10'd5, 7'h05);
    readExpect("sweep700", 10'd700, 7'h3C);
    readExpect("sweep1023", 10'd1023, 7'h7F);

    // RAW forwarding in RD
    initWrite(10'd12, 7'h20);
    readExpect("raw_pre", 10'd12, 7'h20);
    readStart("raw", 10'd12);
    ctxStateUpdate_vld = 1'b1; ctxStateUpdate = 7'h21;
    #1;
    chk("raw_wb_we", 32'(ctx_we), 32'd1);
    chk("raw_wb_addr", 32'(ctx_addr), 32'd12);
    chk("raw_wb_wdata", 32'(ctx_wdata), 32'h21);
    step();
    ctxStateUpdate_vld = 1'b0;
    #1;
    chk("raw_vld", 32'(ctxState_vld), 32'd1);
    chk("raw_data", 32'(ctxState), 32'h21);
    deliver();

    // HOLD overwrite
    initWrite(10'd40, 7'h10);
    readStart("hold", 10'd40);
    step();
    #1;
    chk("hold_data0", 32'(ctxState), 32'h10);
    init_vld = 1'b1; init_addr = 10'd40; init_data = 7'h55;
    #1;
    chk("hold_init_rdy", 32'(init_rdy), 32'd1);
    step();
    init_vld = 1'b0;
    #1;
    chk("hold_vld1", 32'(ctxState_vld), 32'd1);
    chk("hold_data1", 32'(ctxState), 32'h55);
    init_vld = 1'b1; init_addr = 10'd41; init_data = 7'h33;
    step();
    init_vld = 1'b0;
    #1;
    chk("hold_vld2", 32'(ctxState_vld), 32'd1);
    chk("hold_data2", 32'(ctxState), 32'h55);
    deliver();

    // Priority collision: update (to 40) vs init (41) vs read (41)
    ctxStateUpdate_vld = 1'b1; ctxStateUpdate = 7'h11;
    init_vld = 1'b1; init_addr = 10'd41; init_data = 7'h22;
    rd_req = 1'b1; rd_addr = 10'd41;
    #1;
    chk("col0_we", 32'(ctx_we), 32'd1);
    chk("col0_addr", 32'(ctx_addr), 32'd40);
    chk("col0_wdata", 32'(ctx_wdata), 32'h11);
    chk("col0_init_rdy", 32'(init_rdy), 32'd0);
    chk("col0_gnt", 32'(rd_gnt), 32'd0);
    step();
    ctxStateUpdate_vld = 1'b0;
    #1;
    chk("col1_we", 32'(ctx_we), 32'd1);
    chk("col1_addr", 32'(ctx_addr), 32'd41);
    chk("col1_wdata", 32'(ctx_wdata), 32'h22);
    chk("col1_gnt", 32'(rd_gnt), 32'd0);
    step();
    init_vld = 1'b0;
    #1;
    chk("col2_addr", 32'(ctx_addr), 32'd41);
    chk("col2_we", 32'(ctx_we), 32'd0);
    rd_req = 1'b0;
    rd_req = 1'b1;
    readExpect("col2", 10'd41, 7'h22);
    readExpect("col_upd", 10'd40, 7'h11);

    // Decode loop against a memory model
    for (int j = 0; j < 8; j++) begin
      model[j] = 7'($urandom);
      initWrite(10'(100 + j), model[j]);
    end
    for (int k = 0; k < 200; k++) begin
      a = 3'($urandom_range(7));
      readExpect("dec", 10'(100 + 32'(a)), model[a]);
      nv = 7'($urandom);
      ctxStateUpdate_vld = 1'b1; ctxStateUpdate = nv;
      #1;
      chk("dec_wb_addr", 32'(ctx_addr), 32'(100 + 32'(a)));
      step();
      ctxStateUpdate_vld = 1'b0;
      model[a] = nv;
      #1;
      chk("dec_busy_clr", 32'(busy), 32'd0);
    end

    // Reset while in HOLD
    readStart("rh", 10'd5);
    step();
    #1;
    chk("rh_vld_pre", 32'(ctxState_vld), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rh_vld", 32'(ctxState_vld), 32'd0);
    chk("rh_busy", 32'(busy), 32'd0);
    chk("rh_we", 32'(ctx_we), 32'd0);
    chk("rh_re", 32'(ctx_re), 32'd0);
    chk("rh_state", 32'(ctxState), 32'd0);
    readExpect("rh_new", 10'd700, 7'h3C);

    step();
    chk("we_re_excl", 32'(weReBoth), 32'd0);
    chk("wb_before_delivery", 32'(badWb), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
